// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
// It sits between the CPU MA stage (req/ready) and a word-wide backing memory (req/ack).
// Read misses refill the whole line. Stores always write through and update the line only on a hit.
// Optional build macro DCACHE_STATS_EN adds the hit_cnt / miss_cnt outputs.
module dcache_dm #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int WA_W  = ADDR_W - 2;              // word-address width
    localparam int TAG_W = WA_W - OFF_W - IDX_W;
    localparam int DEPTH = SETS * LINE_WORDS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_WRITE,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;

    // Latched request
    logic                r_we;
    logic [WA_W-1:0]     r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_hit;

    // Refill beat counter
    logic [OFF_W-1:0]    r_beat;
    logic [OFF_W-1:0]    w_beat_d;

    // Cache storage
    logic [SETS-1:0]     r_valid;
    logic [TAG_W-1:0]    r_tag  [SETS];
    logic [DATA_W-1:0]   r_data [DEPTH];

    // Registered outputs and their next values
    logic [DATA_W-1:0]   r_cpu_rdata, w_cpu_rdata_d;
    logic                r_cpu_ready, w_cpu_ready_d;
    logic                r_mem_req,   w_mem_req_d;
    logic                r_mem_we,    w_mem_we_d;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_d;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_d;

    // Address decode of the latched request
    logic [OFF_W-1:0]      w_off;
    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [WA_W-OFF_W-1:0] w_line_hi;
    logic                  w_hit;
    logic                  w_ack;
    logic                  w_last;
    logic [OFF_W-1:0]      w_beat_inc;
    logic [IDX_W+OFF_W-1:0] w_word_sel;
    logic [IDX_W+OFF_W-1:0] w_fill_sel;
    logic                  w_unused_addr;

    assign w_off      = r_waddr[OFF_W-1:0];
    assign w_idx      = r_waddr[OFF_W +: IDX_W];
    assign w_tag      = r_waddr[WA_W-1 -: TAG_W];
    assign w_line_hi  = r_waddr[WA_W-1:OFF_W];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // An ack that arrives while no request is outstanding is ignored.
    assign w_ack      = mem_ack && r_mem_req;
    assign w_last     = (r_beat == OFF_W'(LINE_WORDS - 1));
    assign w_beat_inc = r_beat + OFF_W'(1);
    assign w_word_sel = {w_idx, w_off};
    assign w_fill_sel = {w_idx, r_beat};
    // The byte-offset bits play no part in a word-wide cache.
    assign w_unused_addr = ^cpu_addr[1:0];

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ready = r_cpu_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // State register; reset abandons any operation in flight.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and next-output decode.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_next        = r_state;
        w_beat_d      = r_beat;
        w_cpu_rdata_d = r_cpu_rdata;
        w_cpu_ready_d = 1'b0;
        w_mem_req_d   = r_mem_req;
        w_mem_we_d    = r_mem_we;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_we) begin
                    w_next        = S_WRITE;
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = 1'b1;
                    w_mem_addr_d  = {r_waddr, 2'b00};
                    w_mem_wdata_d = r_wdata;
                end else if (w_hit) begin
                    w_next        = S_IDLE;
                    w_cpu_ready_d = 1'b1;
                    w_cpu_rdata_d = r_data[w_word_sel];
                end else begin
                    w_next       = S_REFILL;
                    w_mem_req_d  = 1'b1;
                    w_mem_we_d   = 1'b0;
                    w_mem_addr_d = {w_line_hi, {OFF_W{1'b0}}, 2'b00};
                end
            end
            S_REFILL: begin
                if (w_ack) begin
                    w_beat_d = w_beat_inc;
                    if (r_beat == w_off) w_cpu_rdata_d = mem_rdata;
                    if (w_last) begin
                        w_next      = S_RESP;
                        w_mem_req_d = 1'b0;
                    end else begin
                        w_mem_addr_d = {w_line_hi, w_beat_inc, 2'b00};
                    end
                end
            end
            S_WRITE: begin
                if (w_ack) begin
                    w_next        = S_IDLE;
                    w_mem_req_d   = 1'b0;
                    w_mem_we_d    = 1'b0;
                    w_cpu_ready_d = 1'b1;
                end
            end
            S_RESP: begin
                w_next        = S_IDLE;
                w_cpu_ready_d = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output, beat, request-latch and valid-bit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat      <= '0;
            r_cpu_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_hit       <= 1'b0;
            r_valid     <= '0;
        end else begin
            r_beat      <= w_beat_d;
            r_cpu_rdata <= w_cpu_rdata_d;
            r_cpu_ready <= w_cpu_ready_d;
            r_mem_req   <= w_mem_req_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            if (r_state == S_IDLE && cpu_req) begin
                r_we    <= cpu_we;
                r_waddr <= cpu_addr[ADDR_W-1:2];
                r_wdata <= cpu_wdata;
            end
            if (r_state == S_LOOKUP) begin
                r_hit <= w_hit;
                // A line being refilled stays invalid until its last beat lands.
                if (!r_we && !w_hit) r_valid[w_idx] <= 1'b0;
            end
            if (r_state == S_REFILL && w_ack && w_last) r_valid[w_idx] <= 1'b1;
        end
    end

    // Tag and data array writes: refill beats and store hits.
    // NOTE: the arrays are not reset; the valid bits alone decide whether their contents count.
    always_ff @(posedge clk) begin
        if (r_state == S_REFILL && w_ack) begin
            r_data[w_fill_sel] <= mem_rdata;
            if (w_last) r_tag[w_idx] <= w_tag;
        end
        if (r_state == S_WRITE && w_ack && r_hit) r_data[w_word_sel] <= r_wdata;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Count each lookup outcome, for loads and stores alike.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
            else       r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: scoreboard bench for dcache_dm (LINE_WORDS=4, SETS=64).
// The stimulus pushes the expected memory beats and CPU responses into queues.
// A memory responder and a CPU monitor pop those queues and compare.
// The memory model returns 0xA5A50000 ^ addr and acks in the second cycle of each beat.
module tb_dcache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_dm #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(64)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        chk_data;
        logic [31:0] rdata;
        int          lat;        // 0 = latency not checked
        int          issue_cyc;
    } cpu_exp_t;

    mem_exp_t mem_q[$];
    cpu_exp_t cpu_q[$];
    int       n_cmp  = 0;
    int       n_fail = 0;
    int       cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Backing memory: acks each beat in its second cycle and checks it against the scoreboard.
    initial begin
        int       wait_cnt;
        mem_exp_t e;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1 && rst === 1'b0) begin
                if (wait_cnt == 1) begin
                    wait_cnt  = 0;
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hA5A5_0000 ^ mem_addr;
                    if (mem_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL mem_unexpected: got beat addr %h we %b, expected none", mem_addr, mem_we);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_we", mem_we, e.we);
                        check("mem_addr", mem_addr, e.addr);
                        if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                    end
                end else begin
                    wait_cnt = 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // CPU monitor: every cpu_ready pulse is matched against the next expected response.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ready === 1'b1) begin
                if (cpu_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL cpu_unexpected: got ready with rdata %h, expected none", cpu_rdata);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.chk_data) check("cpu_rdata", cpu_rdata, e.rdata);
                    if (e.lat != 0) check("hit_latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) mem_q.push_back('{we: 1'b0, addr: base + 32'(4 * i), wdata: '0});
    endtask

    // Present one request for one cycle, then scramble the inputs.
    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_we    = ~we;
        cpu_addr  = 32'hFFFF_FFF0;
        cpu_wdata = 32'h5555_AAAA;
    endtask

    // Full transaction: expectation pushed at issue, then a bounded wait for cpu_ready.
    // It returns on the ready cycle, so the next request goes out back-to-back.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic chk, input logic [31:0] exp_rdata, input int lat);
        int n;
        cpu_q.push_back('{chk_data: chk, rdata: exp_rdata, lat: lat, issue_cyc: cyc});
        drive_req(we, addr, wdata);
        n = 0;
        while (cpu_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("resp_seen", cpu_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        logic found;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'h0);
        check("rst_miss_cnt", miss_cnt, 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // 1: cold miss refills line 0x100 in beat order
        push_line(32'h100);
        xact(1'b0, 32'h104, '0, 1'b1, 32'hA5A5_0104, 0);
        // 2: hit in the same line, no memory traffic
        xact(1'b0, 32'h108, '0, 1'b1, 32'hA5A5_0108, 2);
        // 3: store hit writes through and updates the line
        mem_q.push_back('{we: 1'b1, addr: 32'h108, wdata: 32'hDEAD_BEEF});
        xact(1'b1, 32'h108, 32'hDEAD_BEEF, 1'b0, '0, 0);
        xact(1'b0, 32'h108, '0, 1'b1, 32'hDEAD_BEEF, 2);
        // 4: store miss does not allocate; the following load refills
        mem_q.push_back('{we: 1'b1, addr: 32'h2000, wdata: 32'h1234_5678});
        xact(1'b1, 32'h2000, 32'h1234_5678, 1'b0, '0, 0);
        push_line(32'h2000);
        xact(1'b0, 32'h2000, '0, 1'b1, 32'hA5A5_2000, 0);
        // 5: conflict in set 16 evicts, then re-refills 0x100
        push_line(32'h500);
        xact(1'b0, 32'h500, '0, 1'b1, 32'hA5A5_0500, 0);
        push_line(32'h100);
        xact(1'b0, 32'h104, '0, 1'b1, 32'hA5A5_0104, 0);
        xact(1'b0, 32'h10C, '0, 1'b1, 32'hA5A5_010C, 2);
        xact(1'b0, 32'h2004, '0, 1'b1, 32'hA5A5_2004, 2);
`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt, 32'd5);
        check("miss_cnt", miss_cnt, 32'd5);
`endif

        // 6: reset during beat 2 of a refill of 0x500
        mem_q.push_back('{we: 1'b0, addr: 32'h500, wdata: '0});
        mem_q.push_back('{we: 1'b0, addr: 32'h504, wdata: '0});
        drive_req(1'b0, 32'h500, '0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1 && mem_addr === 32'h508) found = 1'b1;
        end
        check("beat2_reached", found, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_cpu_ready", cpu_ready, 1'b0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        check("midrst_beats_left", 32'(mem_q.size()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
`ifdef DCACHE_STATS_EN
        check("midrst_hit_cnt", hit_cnt, 32'h0);
        check("midrst_miss_cnt", miss_cnt, 32'h0);
`endif
        push_line(32'h100);
        xact(1'b0, 32'h104, '0, 1'b1, 32'hA5A5_0104, 0);
        push_line(32'h500);
        xact(1'b0, 32'h500, '0, 1'b1, 32'hA5A5_0500, 0);
`ifdef DCACHE_STATS_EN
        check("final_hit_cnt", hit_cnt, 32'd0);
        check("final_miss_cnt", miss_cnt, 32'd2);
`endif
        repeat (4) @(negedge clk);
        check("mem_q_left", 32'(mem_q.size()), 32'd0);
        check("cpu_q_left", 32'(cpu_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
